ps2_mouse_tracker: RTL and testbench

Parametrised PS/2 mouse packet decoder and cursor tracker; next generation of the mouse top-level path. Consumes the byte stream from the PS/2 receive block after initialisation has completed, and assembles 3-byte (or 4-byte wheel) packets with sync checking and inter-byte timeout. Publishes per-packet buttons, deltas and overflow flags, and maintains a clamped absolute cursor position for the display/CPU side.

---
 rtl/ps2_mouse_tracker.sv | 232 +++++++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker
// PS/2 mouse packet decoder and clamped absolute cursor tracker.
// Assembles 3-byte packets (4-byte IntelliMouse packets when the macro
// PS2_WHEEL_EN is defined) from the receiver byte stream. Byte 0 must have
// bit 3 set (sync). A partial packet is dropped after TIMEOUT idle cycles.
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   track_en          : 1 lets committed packets move the cursor
//   set_pos, set_x/y  : one-cycle cursor load (clamped), wins over a packet
//   pkt_valid         : one-cycle pulse when the packet outputs update
//   btn, dx, dy       : {mid,right,left}, signed 9-bit deltas (dy up-positive)
//   x_ovf, y_ovf      : overflow bits from byte 0
//   wheel             : byte3[3:0] (tied to 0 without PS2_WHEEL_EN)
//   cur_x, cur_y      : cursor position, Y grows downwards on screen
//   sync_err          : one-cycle pulse when a byte 0 candidate is rejected
module ps2_mouse_tracker #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int TIMEOUT = 100000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic           track_en,
  input  logic           set_pos,
  input  logic [X_W-1:0] set_x,
  input  logic [Y_W-1:0] set_y,
  output logic           pkt_valid,
  output logic [2:0]     btn,
  output logic [8:0]     dx,
  output logic [8:0]     dy,
  output logic           x_ovf,
  output logic           y_ovf,
  output logic [3:0]     wheel,
  output logic [X_W-1:0] cur_x,
  output logic [Y_W-1:0] cur_y,
  output logic           sync_err
);

  localparam int CW   = ((X_W > Y_W) ? X_W : Y_W) + 2;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic signed [CW-1:0] XMAX_S  = CW'(X_MAX);
  localparam logic signed [CW-1:0] YMAX_S  = CW'(Y_MAX);
  localparam logic [X_W-1:0]       XMAX_U  = X_W'(X_MAX);
  localparam logic [Y_W-1:0]       YMAX_U  = Y_W'(Y_MAX);

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_e;

`ifdef PS2_WHEEL_EN
  localparam state_e LAST = B3;
`else
  localparam state_e LAST = B2;
`endif

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      b0_q, b1_q;
  logic [7:0]      byte2_s;
  logic            timeout_s, commit_s;

  logic            pkt_valid_q, pkt_valid_d, sync_err_q, sync_err_d;
  logic [2:0]      btn_q, btn_d;
  logic [8:0]      dx_q, dx_d, dy_q, dy_d;
  logic            x_ovf_q, x_ovf_d, y_ovf_q, y_ovf_d;
  logic [3:0]      wheel_q, wheel_d;
  logic [X_W-1:0]  cur_x_q, cur_x_d, clx_s, setx_s;
  logic [Y_W-1:0]  cur_y_q, cur_y_d, cly_s, sety_s;
  logic signed [8:0]    mdx_s, mdy_s;
  logic signed [CW-1:0] nx_s, ny_s;

`ifdef PS2_WHEEL_EN
  logic [7:0] b2_q;
  assign byte2_s = b2_q;
`else
  // Without the wheel the packet commits on byte 2 itself.
  assign byte2_s = rx_data;
`endif

  assign timeout_s = (state_q != B0) && !rx_valid && (to_cnt_q == TO_LAST);
  assign commit_s  = rx_valid && (state_q == LAST);

  // State register, byte latches and inter-byte timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= B0;
      to_cnt_q <= '0;
      b0_q     <= 8'h00;
      b1_q     <= 8'h00;
`ifdef PS2_WHEEL_EN
      b2_q     <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      if (rx_valid && state_q == B0 && rx_data[3]) b0_q <= rx_data;
      if (rx_valid && state_q == B1) b1_q <= rx_data;
`ifdef PS2_WHEEL_EN
      if (rx_valid && state_q == B2) b2_q <= rx_data;
`endif
    end
  end

  // Next-state logic: one byte per strobe, timeout abandons a partial packet.
  always_comb begin
    state_d = state_q;
    case (state_q)
      B0: begin
        if (rx_valid && rx_data[3]) state_d = B1;
        else                        state_d = B0;
      end
      B1: begin
        if (rx_valid)       state_d = B2;
        else if (timeout_s) state_d = B0;
        else                state_d = B1;
      end
      B2: begin
        if (rx_valid)       state_d = (LAST == B2) ? B0 : B3;
        else if (timeout_s) state_d = B0;
        else                state_d = B2;
      end
      B3: begin
        if (rx_valid || timeout_s) state_d = B0;
        else                       state_d = B3;
      end
      default: state_d = B0;
    endcase
    // Counter only runs while a packet is in progress.
    if (rx_valid || timeout_s || state_q == B0) to_cnt_d = '0;
    else                                        to_cnt_d = to_cnt_q + TO_W'(1);
  end

  // Output logic: packet fields on commit, clamped cursor arithmetic.
  always_comb begin
    pkt_valid_d = commit_s;
    sync_err_d  = rx_valid && (state_q == B0) && !rx_data[3];
    btn_d   = btn_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_ovf_d = x_ovf_q;
    y_ovf_d = y_ovf_q;
    wheel_d = wheel_q;
    if (commit_s) begin
      btn_d   = b0_q[2:0];
      dx_d    = {b0_q[4], b1_q};
      dy_d    = {b0_q[5], byte2_s};
      x_ovf_d = b0_q[6];
      y_ovf_d = b0_q[7];
`ifdef PS2_WHEEL_EN
      wheel_d = rx_data[3:0];
`else
      wheel_d = 4'h0;
`endif
    end else begin
      btn_d = btn_q;
    end

    // An overflowed axis does not move the cursor.
    mdx_s = b0_q[6] ? 9'sd0 : $signed({b0_q[4], b1_q});
    mdy_s = b0_q[7] ? 9'sd0 : $signed({b0_q[5], byte2_s});
    nx_s  = $signed({{(CW-X_W){1'b0}}, cur_x_q}) + $signed({{(CW-9){mdx_s[8]}}, mdx_s});
    ny_s  = $signed({{(CW-Y_W){1'b0}}, cur_y_q}) - $signed({{(CW-9){mdy_s[8]}}, mdy_s});

    if (nx_s[CW-1])        clx_s = '0;
    else if (nx_s > XMAX_S) clx_s = XMAX_U;
    else                    clx_s = nx_s[X_W-1:0];
    if (ny_s[CW-1])        cly_s = '0;
    else if (ny_s > YMAX_S) cly_s = YMAX_U;
    else                    cly_s = ny_s[Y_W-1:0];

    if (set_x > XMAX_U) setx_s = XMAX_U;
    else                setx_s = set_x;
    if (set_y > YMAX_U) sety_s = YMAX_U;
    else                sety_s = set_y;

    if (set_pos) begin
      cur_x_d = setx_s;
      cur_y_d = sety_s;
    end else if (commit_s && track_en) begin
      cur_x_d = clx_s;
      cur_y_d = cly_s;
    end else begin
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      btn_q       <= 3'b000;
      dx_q        <= 9'h000;
      dy_q        <= 9'h000;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
      wheel_q     <= 4'h0;
      cur_x_q     <= X_W'(X_INIT);
      cur_y_q     <= Y_W'(Y_INIT);
    end else begin
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
      btn_q       <= btn_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      x_ovf_q     <= x_ovf_d;
      y_ovf_q     <= y_ovf_d;
      wheel_q     <= wheel_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign sync_err  = sync_err_q;
  assign btn       = btn_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign x_ovf     = x_ovf_q;
  assign y_ovf     = y_ovf_q;
  assign wheel     = wheel_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed testbench for ps2_mouse_tracker (default 3-byte build; the wheel
// scenario is added when PS2_WHEEL_EN is defined).
module tb_ps2_mouse_tracker;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, track_en, set_pos;
  logic [9:0] set_x, set_y;
  logic       pkt_valid, x_ovf, y_ovf, sync_err;
  logic [2:0] btn;
  logic [8:0] dx, dy;
  logic [3:0] wheel;
  logic [9:0] cur_x, cur_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_mouse_tracker #(
    .X_W(10), .Y_W(10), .X_MAX(639), .Y_MAX(479),
    .X_INIT(320), .Y_INIT(240), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .track_en(track_en), .set_pos(set_pos), .set_x(set_x), .set_y(set_y),
    .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy), .x_ovf(x_ovf),
    .y_ovf(y_ovf), .wheel(wheel), .cur_x(cur_x), .cur_y(cur_y),
    .sync_err(sync_err)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sp);
    rx_data  = b;
    rx_valid = 1'b1;
    set_pos  = sp;
    step();
    rx_valid = 1'b0;
    set_pos  = 1'b0;
  endtask

  // Sends a full packet; set_pos (if sp) coincides with the final byte.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic sp);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
`ifdef PS2_WHEEL_EN
    send_byte(b2, 1'b0);
    send_byte(8'h00, sp);
`else
    send_byte(b2, sp);
`endif
  endtask

  task automatic do_set(input logic [9:0] x, input logic [9:0] y);
    set_x   = x;
    set_y   = y;
    set_pos = 1'b1;
    step();
    set_pos = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (cur_x !== 10'd320) begin errors++; $display("FAIL reset_cur_x got %0d expected 320", cur_x); end
    checks++; if (cur_y !== 10'd240) begin errors++; $display("FAIL reset_cur_y got %0d expected 240", cur_y); end
    checks++; if ({pkt_valid, sync_err, x_ovf, y_ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b expected 0000", {pkt_valid, sync_err, x_ovf, y_ovf}); end
    checks++; if ({btn, dx, dy, wheel} !== 25'h0) begin errors++; $display("FAIL reset_fields got %h expected 0", {btn, dx, dy, wheel}); end
  endtask

  task automatic test_basic_packet();
    // byte0 0x29: left button, Y sign set; dx=+5, dy={1,FD}=-3
    send_pkt(8'h29, 8'h05, 8'hFD, 1'b0);
    checks++; if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_pkt_valid got %b expected 1", pkt_valid); end
    checks++; if (btn !== 3'b001) begin errors++; $display("FAIL basic_btn got %b expected 001", btn); end
    checks++; if (dx !== 9'h005) begin errors++; $display("FAIL basic_dx got %h expected 005", dx); end
    checks++; if (dy !== 9'h1FD) begin errors++; $display("FAIL basic_dy got %h expected 1fd", dy); end
    checks++; if (cur_x !== 10'd325 || cur_y !== 10'd243) begin errors++; $display("FAIL basic_cursor got %0d,%0d expected 325,243", cur_x, cur_y); end
    checks++; if (wheel !== 4'h0) begin errors++; $display("FAIL basic_wheel got %h expected 0", wheel); end
    step();
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL basic_pkt_pulse got %b expected 0", pkt_valid); end
  endtask

  task automatic test_sync_err();
    send_byte(8'h00, 1'b0);
    checks++; if (sync_err !== 1'b1 || pkt_valid !== 1'b0) begin errors++; $display("FAIL sync_pulse got %b%b expected 10", sync_err, pkt_valid); end
    step();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL sync_one_cycle got %b expected 0", sync_err); end
    send_pkt(8'h08, 8'h00, 8'h00, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h000 || dy !== 9'h000 || btn !== 3'b000) begin errors++; $display("FAIL sync_recover got v=%b dx=%h dy=%h btn=%b expected 1,000,000,000", pkt_valid, dx, dy, btn); end
    checks++; if (cur_x !== 10'd325 || cur_y !== 10'd243) begin errors++; $display("FAIL sync_cursor got %0d,%0d expected 325,243", cur_x, cur_y); end
  endtask

  task automatic test_clamp();
    do_set(10'd635, 10'd243);
    checks++; if (cur_x !== 10'd635 || cur_y !== 10'd243) begin errors++; $display("FAIL setpos_load got %0d,%0d expected 635,243", cur_x, cur_y); end
    send_pkt(8'h08, 8'h14, 8'h00, 1'b0);
    checks++; if (cur_x !== 10'd639) begin errors++; $display("FAIL clamp_x_high got %0d expected 639", cur_x); end
    do_set(10'd10, 10'd243);
    send_pkt(8'h18, 8'hEC, 8'h00, 1'b0);
    checks++; if (dx !== 9'h1EC || cur_x !== 10'd0) begin errors++; $display("FAIL clamp_x_low got dx=%h x=%0d expected 1ec,0", dx, cur_x); end
    // Y sign 0 here: dy=+253 moves the cursor up past the top
    send_pkt(8'h09, 8'h05, 8'hFD, 1'b0);
    checks++; if (dy !== 9'h0FD || cur_y !== 10'd0 || cur_x !== 10'd5) begin errors++; $display("FAIL clamp_y_low got dy=%h x=%0d y=%0d expected 0fd,5,0", dy, cur_x, cur_y); end
    do_set(10'd5, 10'd470);
    send_pkt(8'h28, 8'h00, 8'hF6, 1'b0);
    checks++; if (cur_y !== 10'd479) begin errors++; $display("FAIL clamp_y_high got %0d expected 479", cur_y); end
    do_set(10'd700, 10'd1000);
    checks++; if (cur_x !== 10'd639 || cur_y !== 10'd479) begin errors++; $display("FAIL setpos_clamp got %0d,%0d expected 639,479", cur_x, cur_y); end
  endtask

  task automatic test_overflow();
    do_set(10'd320, 10'd240);
    send_pkt(8'h48, 8'h7F, 8'h00, 1'b0);
    checks++; if (x_ovf !== 1'b1 || y_ovf !== 1'b0 || dx !== 9'h07F) begin errors++; $display("FAIL xovf_fields got ovf=%b%b dx=%h expected 10,07f", x_ovf, y_ovf, dx); end
    checks++; if (cur_x !== 10'd320) begin errors++; $display("FAIL xovf_cursor got %0d expected 320", cur_x); end
    send_pkt(8'h88, 8'h00, 8'h10, 1'b0);
    checks++; if (x_ovf !== 1'b0 || y_ovf !== 1'b1 || dy !== 9'h010) begin errors++; $display("FAIL yovf_fields got ovf=%b%b dy=%h expected 01,010", x_ovf, y_ovf, dy); end
    checks++; if (cur_y !== 10'd240) begin errors++; $display("FAIL yovf_cursor got %0d expected 240", cur_y); end
  endtask

  task automatic test_timeout();
    logic pulses;
    pulses = 1'b0;
    send_byte(8'h08, 1'b0);
    for (int i = 0; i < TO; i++) begin
      step();
      if (pkt_valid || sync_err) pulses = 1'b1;
    end
    checks++; if (pulses !== 1'b0) begin errors++; $display("FAIL timeout_no_pulse got %b expected 0", pulses); end
    send_byte(8'h08, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL timeout_discard got %b expected 0", pkt_valid); end
    send_byte(8'h00, 1'b0);
`ifdef PS2_WHEEL_EN
    send_byte(8'h00, 1'b0);
`endif
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h001 || cur_x !== 10'd321) begin errors++; $display("FAIL timeout_pkt got v=%b dx=%h x=%0d expected 1,001,321", pkt_valid, dx, cur_x); end
    // one idle cycle short of the timeout keeps the packet alive
    send_byte(8'h08, 1'b0);
    for (int i = 0; i < TO - 1; i++) step();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef PS2_WHEEL_EN
    send_byte(8'h00, 1'b0);
`endif
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h002 || cur_x !== 10'd323) begin errors++; $display("FAIL timeout_edge got v=%b dx=%h x=%0d expected 1,002,323", pkt_valid, dx, cur_x); end
  endtask

  task automatic test_track_en();
    track_en = 1'b0;
    send_pkt(8'h0C, 8'h05, 8'h00, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h005 || btn !== 3'b100) begin errors++; $display("FAIL frozen_fields got v=%b dx=%h btn=%b expected 1,005,100", pkt_valid, dx, btn); end
    checks++; if (cur_x !== 10'd323 || cur_y !== 10'd240) begin errors++; $display("FAIL frozen_cursor got %0d,%0d expected 323,240", cur_x, cur_y); end
    track_en = 1'b1;
  endtask

  task automatic test_set_pos_commit();
    set_x = 10'd700;
    set_y = 10'd5;
    send_pkt(8'h0A, 8'h0A, 8'h00, 1'b1);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h00A || btn !== 3'b010) begin errors++; $display("FAIL setcommit_fields got v=%b dx=%h btn=%b expected 1,00a,010", pkt_valid, dx, btn); end
    checks++; if (cur_x !== 10'd639 || cur_y !== 10'd5) begin errors++; $display("FAIL setcommit_cursor got %0d,%0d expected 639,5", cur_x, cur_y); end
  endtask

  task automatic test_back_to_back();
    do_set(10'd100, 10'd100);
    send_pkt(8'h08, 8'h01, 8'h00, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h001 || cur_x !== 10'd101) begin errors++; $display("FAIL b2b_first got v=%b dx=%h x=%0d expected 1,001,101", pkt_valid, dx, cur_x); end
    send_pkt(8'h28, 8'h02, 8'hFF, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h002 || cur_x !== 10'd103 || cur_y !== 10'd101) begin errors++; $display("FAIL b2b_second got v=%b dx=%h x=%0d y=%0d expected 1,002,103,101", pkt_valid, dx, cur_x, cur_y); end
    step();
    step();
    checks++; if (pkt_valid !== 1'b0 || dx !== 9'h002 || dy !== 9'h1FF) begin errors++; $display("FAIL hold_outputs got v=%b dx=%h dy=%h expected 0,002,1ff", pkt_valid, dx, dy); end
  endtask

  task automatic test_reset_mid_packet();
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (cur_x !== 10'd320 || cur_y !== 10'd240 || dx !== 9'h000) begin errors++; $display("FAIL midrst_state got x=%0d y=%0d dx=%h expected 320,240,000", cur_x, cur_y, dx); end
    send_pkt(8'h08, 8'h07, 8'h00, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || dx !== 9'h007 || cur_x !== 10'd327) begin errors++; $display("FAIL midrst_pkt got v=%b dx=%h x=%0d expected 1,007,327", pkt_valid, dx, cur_x); end
  endtask

`ifdef PS2_WHEEL_EN
  task automatic test_wheel();
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL wheel_no_early got %b expected 0", pkt_valid); end
    send_byte(8'h0F, 1'b0);
    checks++; if (pkt_valid !== 1'b1 || wheel !== 4'hF) begin errors++; $display("FAIL wheel_value got v=%b w=%h expected 1,f", pkt_valid, wheel); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    track_en = 1'b1;
    set_pos  = 1'b0;
    set_x    = 10'd0;
    set_y    = 10'd0;
    test_reset();
    test_basic_packet();
    test_sync_err();
    test_clamp();
    test_overflow();
    test_timeout();
    test_track_en();
    test_set_pos_commit();
    test_back_to_back();
    test_reset_mid_packet();
`ifdef PS2_WHEEL_EN
    test_wheel();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
